pipe_fetch_unit: RTL and testbench

- Instruction-fetch (IF) stage, directly upstream of the IF/ID instruction register.
- Holds the PC and selects the next PC (sequential, branch, register jump, jump).
- Drives a ready/ack instruction-memory interface.
- Presents newInst plus a write strobe (wir) to the IF/ID register. A one-entry hold buffer ensures no fetched instruction is lost while decode stalls.

---
 rtl/cpu_pipe_pkg.sv | 17 +
 rtl/pipe_pc_reg.sv | 21 ++
 rtl/pipe_fetch_unit.sv | 112 +++++++++++
 tb/tb_pipe_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the pipeline front end: next-PC select codes,
// fetch FSM states and the bubble instruction.
package cpu_pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetchState_t;

endpackage

// File: rtl/pipe_pc_reg.sv
// Program counter register: async active-high clear to RESET_PC, loads d when load=1.
module pipe_pc_reg #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch stage: PC, next-PC select, imem ready/ack handshake and a one-entry hold buffer.
// Define PIPE_FETCH_PERF_EN to build the fetch/stall performance counters.
module pipe_fetch_unit
    import cpu_pipe_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      pcsource,
    input  logic [PC_W-1:0] bpc,
    input  logic [PC_W-1:0] rpc,
    input  logic [PC_W-1:0] jpc,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     newInst,
    output logic [PC_W-1:0] pc4,
    output logic            wir,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall
);

    fetchState_t     state;
    logic [31:0]     holdBuf;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] pcNext;
    logic            pcLoad;
    logic            inReq;

    pipe_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk  (clk),
        .clr  (clr),
        .load (pcLoad),
        .d    (pcNext),
        .q    (pc)
    );

    assign pc4 = pc + PC_W'(4);

    always_comb begin
        npc = pc4;
        case (pcsource)
            PCSRC_SEQ: npc = pc4;
            PCSRC_BR:  npc = bpc;
            PCSRC_JR:  npc = rpc;
            PCSRC_J:   npc = jpc;
            default:   npc = pc4;
        endcase
    end

    // clr gates the handshake outputs directly so an in-flight request drops without waiting for an edge
    assign inReq     = (state == S_REQ);
    assign imem_req  = inReq & ~clr;
    assign imem_addr = pc;
    assign wir       = ~clr & ~flush & ~stall & (inReq ? imem_ack : 1'b1);
    assign newInst   = clr ? INST_NOP : (inReq ? imem_rdata : holdBuf);
    assign pcLoad    = flush | wir;
    assign pcNext    = flush ? flush_pc : npc;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_REQ;
            holdBuf <= INST_NOP;
        end else if (flush) begin
            state   <= S_REQ;
            holdBuf <= INST_NOP;
        end else if (inReq) begin
            if (imem_ack && stall) begin
                state   <= S_HOLD;
                holdBuf <= imem_rdata;
            end
        end else if (!stall) begin
            state <= S_REQ;
        end
    end

`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] fetchCnt;
    logic [31:0] stallCnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fetchCnt <= '0;
            stallCnt <= '0;
        end else begin
            if (wir) begin
                fetchCnt <= fetchCnt + 32'd1;
            end
            if (stall && (!inReq || imem_ack)) begin
                stallCnt <= stallCnt + 32'd1;
            end
        end
    end

    assign perf_fetch = fetchCnt;
    assign perf_stall = stallCnt;
`else
    assign perf_fetch = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Scoreboard bench for pipe_fetch_unit: directed scenarios followed by randomized traffic.
module tb_pipe_fetch_unit;
    import cpu_pipe_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc, flush_pc;
    logic        stall, flush;
    logic        imem_req, imem_ack, wir;
    logic [31:0] imem_addr, imem_rdata, newInst, pc4;
    logic [31:0] perf_fetch, perf_stall;

    pipe_fetch_unit #(
        .RESET_PC (RST_PC),
        .PC_W     (32)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .newInst    (newInst),
        .pc4        (pc4),
        .wir        (wir),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        wir;
    } cyc_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } tx_t;

    cyc_t cycQ[$];
    tx_t  txQ[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model: architectural PC, "fetched but not yet delivered" flag, event counts
    logic [31:0] mPc;
    bit          mPending;
    int          mFetch;
    int          mStall;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h2001_0005;
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] nextPc(input logic [1:0] src, input logic [31:0] cur,
                                           input logic [31:0] b, input logic [31:0] r,
                                           input logic [31:0] j);
        case (src)
            2'd0:    return cur + 32'd4;
            2'd1:    return b;
            2'd2:    return r;
            default: return j;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc      = RST_PC;
        mPending = 0;
        mFetch   = 0;
        mStall   = 0;
    endtask

    // drives one cycle starting just after a rising edge; returns just after the next one
    task automatic driveCycle(input bit st, input bit ak, input bit fl, input logic [1:0] src,
                              input logic [31:0] b, input logic [31:0] r,
                              input logic [31:0] j, input logic [31:0] fpc);
        cyc_t c;
        tx_t  t;
        stall      = st;
        imem_ack   = ak;
        flush      = fl;
        pcsource   = src;
        bpc        = b;
        rpc        = r;
        jpc        = j;
        flush_pc   = fpc;
        imem_rdata = ak ? memWord(mPc) : $urandom;
        c.req  = !mPending;
        c.addr = mPc;
        c.wir  = 1'b0;
        if (st && (mPending || ak)) mStall++;
        if (fl) begin
            mPc      = fpc;
            mPending = 0;
        end else if (mPending || ak) begin
            if (!st) begin
                c.wir  = 1'b1;
                t.inst = memWord(mPc);
                t.pc4  = mPc + 32'd4;
                txQ.push_back(t);
                mFetch++;
                mPending = 0;
                mPc      = nextPc(src, mPc, b, r, j);
            end else begin
                mPending = 1;
            end
        end
        cycQ.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input bit st, input bit ak, input logic [1:0] src, input logic [31:0] tgt);
        driveCycle(st, ak, 1'b0, src, tgt, tgt, tgt, 32'h0);
    endtask

    task automatic checkPerf(input string tag);
`ifdef PIPE_FETCH_PERF_EN
        check({tag, "_perf_fetch"}, perf_fetch, 32'(mFetch));
        check({tag, "_perf_stall"}, perf_stall, 32'(mStall));
`else
        check({tag, "_perf_fetch"}, perf_fetch, 32'd0);
        check({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
    endtask

    // monitor: per-cycle handshake check plus in-order delivery check on every wir
    initial begin
        cyc_t c;
        tx_t  t;
        forever begin
            @(negedge clk);
            if (cycQ.size() > 0) begin
                c = cycQ.pop_front();
                check("imem_req", {31'd0, imem_req}, {31'd0, c.req});
                if (c.req) check("imem_addr", imem_addr, c.addr);
                check("wir", {31'd0, wir}, {31'd0, c.wir});
            end
            if (wir === 1'b1) begin
                if (txQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wir: got newInst %h with no expected delivery at %0t",
                             newInst, $time);
                end else begin
                    t = txQ.pop_front();
                    check("newInst", newInst, t.inst);
                    check("pc4", pc4, t.pc4);
                end
            end
        end
    end

    initial begin
        clr        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        pcsource   = 2'd0;
        bpc        = '0;
        rpc        = '0;
        jpc        = '0;
        flush_pc   = '0;
        modelReset();
        #1;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_wir", {31'd0, wir}, 32'd0);
        check("rst_newInst", newInst, INST_NOP);
        check("rst_addr", imem_addr, RST_PC);
        checkPerf("rst");

        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;

        adv(0, 1, 2'd0, 32'h0);          // pc 0
        adv(0, 1, 2'd0, 32'h0);          // pc 4
        adv(1, 1, 2'd0, 32'h0);          // pc 8 acked while stalled
        adv(1, 0, 2'd0, 32'h0);
        adv(1, 0, 2'd0, 32'h0);
        adv(0, 0, 2'd0, 32'h0);          // hold buffer delivered
        adv(0, 1, 2'd0, 32'h0);          // pc 12
        adv(0, 1, PCSRC_BR, 32'h40);     // pc 16 -> branch
        checkPerf("directed");
        adv(0, 1, PCSRC_JR, 32'h60);     // pc 0x40 -> register jump
        adv(0, 0, PCSRC_J, 32'h0);       // wait bubble
        adv(0, 1, PCSRC_J, 32'h80);      // pc 0x60 -> jump
        adv(1, 1, 2'd0, 32'h0);          // pc 0x80 into hold
        driveCycle(1, 0, 1, 2'd0, '0, '0, '0, 32'h100);
        adv(0, 1, 2'd0, 32'h0);          // pc 0x100
        driveCycle(0, 1, 1, 2'd0, '0, '0, '0, 32'hFFFF_FFFC);
        adv(0, 1, 2'd0, 32'h0);          // pc wraps to 0
        adv(0, 1, PCSRC_J, 32'h200);
        adv(0, 0, 2'd0, 32'h0);          // waiting at 0x200

        stall    = 1'b0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        check("midrst_wir", {31'd0, wir}, 32'd0);
        check("midrst_addr", imem_addr, RST_PC);
        check("midrst_newInst", newInst, INST_NOP);
        modelReset();
        checkPerf("midrst");
        @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < 600; i++) begin
            driveCycle($urandom_range(0, 99) < 30,
                       $urandom_range(0, 99) < 65,
                       $urandom_range(0, 99) < 5,
                       2'($urandom_range(0, 3)),
                       $urandom & 32'hFFFF_FFFC,
                       $urandom & 32'hFFFF_FFFC,
                       $urandom & 32'hFFFF_FFFC,
                       $urandom & 32'hFFFF_FFFC);
        end
        checkPerf("random");
        @(negedge clk);
        check("txq_drained", 32'(txQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
